// File: rtl/rx_align_pkg.sv
// Shared constants and types for the 10-bit comma word aligner.
package rx_align_pkg;

  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;
  localparam int         OFF_W     = 4;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic is_comma(input logic [6:0] s);
    return (s == COMMA_POS) || (s == COMMA_NEG);
  endfunction

endpackage

// File: rtl/rx_comma_detect.sv
// Combinational comma search over the ten candidate bit offsets of a 20-bit window.
module rx_comma_detect
  import rx_align_pkg::*;
(
  input  logic [19:0]      win,
  output logic             hit,
  output logic [OFF_W-1:0] hit_off,
  output logic [9:0]       hit_at
);

  // Offset k looks at the 7 earliest bits of slice k, i.e. win[19-k -: 7].
  for (genvar gi = 0; gi < 10; gi++) begin : g_off
    assign hit_at[gi] = is_comma(win[19-gi -: 7]);
  end

  assign hit = |hit_at;

  always_comb begin
    hit_off = '0;
    for (int i = 9; i >= 0; i--) begin
      if (hit_at[i]) hit_off = OFF_W'(i);
    end
  end

endmodule

// File: rtl/rx_comma_align.sv
// Comma word aligner: hunts for a K28.x comma offset, verifies it, then emits aligned symbols.
module rx_comma_align
  import rx_align_pkg::*;
#(
  parameter int LOCK_CNT       = 4,
  parameter int LOSS_CNT       = 8,
  parameter int VERIFY_TIMEOUT = 64
) (
  input  logic       WCLK,
  input  logic       RESET,
  input  logic       enable,
  input  logic [9:0] data_in,
  input  logic       decoder_err,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       sync_ready,
  output logic [3:0] bit_offset,
  output logic [7:0] realign_cnt
);

  localparam int CNT_W  = $clog2(LOCK_CNT + 1);
  localparam int ECNT_W = $clog2(LOSS_CNT + 1);
  localparam int TMO_W  = $clog2(VERIFY_TIMEOUT + 1);

  // Counter values one short of the threshold: the increment that would reach it fires instead.
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CNT - 1);
  localparam logic [ECNT_W-1:0] LOSS_LAST = ECNT_W'(LOSS_CNT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(VERIFY_TIMEOUT - 1);

  state_t            state_q;
  logic [9:0]        prev_q;
  logic [OFF_W-1:0]  off_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ECNT_W-1:0] ecnt_q;
  logic [TMO_W-1:0]  tmo_q;

  logic [19:0]       win;
  logic              hit;
  logic [OFF_W-1:0]  hit_off;
  logic [9:0]        hit_at;
  logic [9:0]        slices [10];
  logic [9:0]        aligned;
  logic              at_off;

  assign win = {prev_q, data_in};

  rx_comma_detect u_detect (
    .win     (win),
    .hit     (hit),
    .hit_off (hit_off),
    .hit_at  (hit_at)
  );

  for (genvar gi = 0; gi < 10; gi++) begin : g_slice
    assign slices[gi] = win[19-gi -: 10];
  end

  assign aligned = (off_q <= OFF_W'(9)) ? slices[off_q] : '0;
  assign at_off  = (off_q <= OFF_W'(9)) ? hit_at[off_q] : 1'b0;

  always_ff @(posedge WCLK) begin
    if (RESET) begin
      state_q     <= ST_HUNT;
      prev_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      ecnt_q      <= '0;
      tmo_q       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      sync_ready  <= 1'b0;
      bit_offset  <= '0;
      realign_cnt <= '0;
    end else begin
      prev_q     <= data_in;
      data_valid <= enable && (state_q == ST_LOCKED);
      if (enable && (state_q == ST_LOCKED)) data_out <= aligned;

      if (!enable) begin
        state_q    <= ST_HUNT;
        cnt_q      <= '0;
        ecnt_q     <= '0;
        tmo_q      <= '0;
        sync_ready <= 1'b0;
        bit_offset <= '0;
      end else begin
        case (state_q)
          ST_HUNT: begin
            if (hit) begin
              off_q  <= hit_off;
              cnt_q  <= CNT_W'(1);
              tmo_q  <= '0;
              ecnt_q <= '0;
              if (LOCK_CNT == 1) begin
                state_q    <= ST_LOCKED;
                sync_ready <= 1'b1;
                bit_offset <= hit_off;
              end else begin
                state_q <= ST_VERIFY;
              end
            end
          end

          ST_VERIFY: begin
            if (at_off) begin
              tmo_q <= '0;
              if (cnt_q == LOCK_LAST) begin
                state_q    <= ST_LOCKED;
                sync_ready <= 1'b1;
                bit_offset <= off_q;
                ecnt_q     <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else if (hit) begin
              off_q <= hit_off;
              cnt_q <= CNT_W'(1);
              tmo_q <= '0;
            end else if (tmo_q == TMO_LAST) begin
              state_q <= ST_HUNT;
              cnt_q   <= '0;
              tmo_q   <= '0;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end

          ST_LOCKED: begin
            // A decoder error outranks a well-placed comma in the same word.
            if (decoder_err || (hit && !at_off)) begin
              if (ecnt_q == LOSS_LAST) begin
                state_q    <= ST_HUNT;
                ecnt_q     <= '0;
                cnt_q      <= '0;
                sync_ready <= 1'b0;
                bit_offset <= '0;
                if (realign_cnt != 8'hFF) realign_cnt <= realign_cnt + 8'd1;
              end else begin
                ecnt_q <= ecnt_q + ECNT_W'(1);
              end
            end else if (at_off) begin
              ecnt_q <= '0;
            end
          end

          default: begin
            state_q <= ST_HUNT;
          end
        endcase
      end
    end
  end

endmodule
